// File: rtl/serial_parity_checker.sv
`default_nettype none
// ============================================================================
//  Module      : serial_parity_checker
//  Description : Receives an LSB-first serial frame of DATA_BITS data bits
//                followed by one parity bit, reassembles the word, checks the
//                parity sense and keeps a saturating parity-error counter.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_parity_checker #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 w,
  input  logic                 w_valid,
  input  logic                 clear,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_done,
  output logic                 parity_err,
  output logic                 busy,
  output logic [7:0]           err_count
);

  // Counter must be able to hold DATA_BITS after the last data bit is taken.
  localparam int unsigned c_cnt_w = $clog2(DATA_BITS + 1);
  localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(DATA_BITS - 1);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
  localparam logic               c_odd    = ODD_PARITY[0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par;
  logic                  w_perr;

  // Parity check result for the bit currently offered as the parity bit.
  assign w_perr = ((r_par ^ w) != c_odd);
  assign busy   = (r_state == S_DATA) || (r_state == S_PARITY);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; clear aborts to IDLE, unused encodings recover to IDLE.
  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_valid) w_next = S_DATA;
        S_DATA:   if (w_valid && (r_cnt == c_last)) w_next = S_PARITY;
        S_PARITY: if (w_valid) w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: shift register (LSB first), running parity, result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      if (clear) begin
        r_cnt   <= '0;
        r_shift <= '0;
        r_par   <= 1'b0;
      end else if (w_valid) begin
        case (r_state)
          S_IDLE: begin
            // Shift register is zero in IDLE, so shifting in from the top
            // leaves bit 0 at the LSB once all data bits have arrived.
            r_shift <= {w, r_shift[DATA_BITS-1:1]};
            r_cnt   <= c_one;
            r_par   <= w;
          end
          S_DATA: begin
            r_shift <= {w, r_shift[DATA_BITS-1:1]};
            r_cnt   <= r_cnt + c_one;
            r_par   <= r_par ^ w;
          end
          S_PARITY: begin
            data_out   <= r_shift;
            parity_err <= w_perr;
            frame_done <= 1'b1;
            if (w_perr && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
          end
          default: begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_parity_checker
//  Description : Scoreboard bench for serial_parity_checker; drives an even
//                and an odd parity instance with the same serial stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_parity_checker;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, w, w_valid, clear;
  logic [7:0] d_e, d_o, cnt_e, cnt_o;
  logic       fd_e, fd_o, pe_e, pe_o, bz_e, bz_o;

  exp_t q_e[$];
  exp_t q_o[$];
  int   done_cyc[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_cnt_e = 0;
  int   m_cnt_o = 0;

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(0)) u_even (
    .clk(clk), .reset(reset), .w(w), .w_valid(w_valid), .clear(clear),
    .data_out(d_e), .frame_done(fd_e), .parity_err(pe_e), .busy(bz_e),
    .err_count(cnt_e)
  );

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1)) u_odd (
    .clk(clk), .reset(reset), .w(w), .w_valid(w_valid), .clear(clear),
    .data_out(d_o), .frame_done(fd_o), .parity_err(pe_o), .busy(bz_o),
    .err_count(cnt_o)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops expected results whenever a DUT reports a completed frame.
  always @(negedge clk) begin
    exp_t x;
    if (fd_e === 1'b1) begin
      if (q_e.size() == 0) chk("even_unexpected_done", 32'd1, 32'd0);
      else begin
        x = q_e.pop_front();
        chk("even_data", {24'd0, d_e}, {24'd0, x.d});
        chk("even_perr", {31'd0, pe_e}, {31'd0, x.pe});
        chk("even_cnt", {24'd0, cnt_e}, {24'd0, x.cnt});
        done_cyc.push_back(cyc);
      end
    end
    if (fd_o === 1'b1) begin
      if (q_o.size() == 0) chk("odd_unexpected_done", 32'd1, 32'd0);
      else begin
        x = q_o.pop_front();
        chk("odd_data", {24'd0, d_o}, {24'd0, x.d});
        chk("odd_perr", {31'd0, pe_o}, {31'd0, x.pe});
        chk("odd_cnt", {24'd0, cnt_o}, {24'd0, x.cnt});
      end
    end
  end

  // Reference model: parity sum over the whole frame decides the verdict.
  task automatic model_frame(input logic [7:0] d, input logic p);
    int   ones;
    bit   e_err, o_err;
    exp_t x;
    ones = $countones(d) + int'(p);
    e_err = (ones % 2) != 0;
    o_err = (ones % 2) != 1;
    if (e_err) m_cnt_e = (m_cnt_e >= 255) ? 255 : m_cnt_e + 1;
    if (o_err) m_cnt_o = (m_cnt_o >= 255) ? 255 : m_cnt_o + 1;
    x.d = d; x.pe = e_err; x.cnt = 8'(m_cnt_e); q_e.push_back(x);
    x.d = d; x.pe = o_err; x.cnt = 8'(m_cnt_o); q_o.push_back(x);
  endtask

  // Driver is always positioned 1 time unit after a rising edge.
  task automatic send_bit(input logic b);
    w = b; w_valid = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic gap(input int n, input bit chk_busy);
    repeat (n) begin
      if (chk_busy) begin
        @(negedge clk);
        chk("busy_in_gap_e", {31'd0, bz_e}, 32'd1);
        chk("busy_in_gap_o", {31'd0, bz_o}, 32'd1);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int g, input bit chk_busy);
    for (int k = 0; k < 8; k++) begin
      send_bit(d[k]);
      gap(g, chk_busy);
    end
    model_frame(d, p);
    send_bit(p);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, {16'd0, d_e, d_o}, 32'd0);
    chk({tag, "_done"}, {30'd0, fd_e, fd_o}, 32'd0);
    chk({tag, "_perr"}, {30'd0, pe_e, pe_o}, 32'd0);
    chk({tag, "_busy"}, {30'd0, bz_e, bz_o}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, cnt_e, cnt_o}, 32'd0);
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus sequence.
  initial begin
    reset = 1'b0; w = 1'b0; w_valid = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Even parity frame, continuous bits; frame_done is a one-cycle pulse.
    send_frame(8'hA5, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("t1_done_pulse", {31'd0, fd_e}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_done_low", {31'd0, fd_e}, 32'd0);
    @(posedge clk); #1;

    // Parity error, then a good frame leaves the counter alone.
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    gap(1, 1'b0);
    send_frame(8'h01, 1'b1, 0, 1'b0);
    gap(1, 1'b0);

    // Gapped frame: busy must stay high throughout, low after parity edge.
    send_frame(8'h3C, 1'b0, 3, 1'b1);
    @(negedge clk);
    chk("gap_busy_after_e", {31'd0, bz_e}, 32'd0);
    chk("gap_busy_after_o", {31'd0, bz_o}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back frames, no idle cycle between them.
    gap(1, 1'b0);
    done_cyc.delete();
    send_frame(8'hFF, 1'b0, 0, 1'b0);
    send_frame(8'h80, 1'b1, 0, 1'b0);
    gap(2, 1'b0);
    chk("b2b_pulses", done_cyc.size(), 32'd2);
    if (done_cyc.size() == 2) chk("b2b_spacing", done_cyc[1] - done_cyc[0], 32'd9);

    // Abort: 4 bits, clear with a bit presented, then a full frame.
    for (int k = 0; k < 4; k++) send_bit(1'(k % 2));
    clear = 1'b1; w = 1'b1; w_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; w_valid = 1'b0;
    @(negedge clk);
    chk("clear_busy", {30'd0, bz_e, bz_o}, 32'd0);
    @(posedge clk); #1;
    send_frame(8'h5A, 1'b0, 0, 1'b0);
    gap(2, 1'b0);

    // Reset mid-frame: all outputs return to zero, no frame completes.
    for (int k = 0; k < 5; k++) send_bit(1'b1);
    reset = 1'b0; w = 1'b1; w_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; w_valid = 1'b0;
    m_cnt_e = 0; m_cnt_o = 0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(posedge clk); #1;

    // Randomized frames with random gaps and random back-to-back spacing.
    for (int n = 0; n < 30; n++) begin
      send_frame(8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
      gap(int'($urandom_range(0, 1)), 1'b0);
    end

    // Saturation: zero frames with even parity bit are errors in odd mode.
    for (int n = 0; n < 260; n++) send_frame(8'h00, 1'b0, 0, 1'b0);
    gap(2, 1'b0);
    chk("sat_odd_cnt", {24'd0, cnt_o}, 32'd255);
    send_frame(8'h00, 1'b1, 0, 1'b0);
    gap(3, 1'b0);
    chk("sat_odd_cnt_hold", {24'd0, cnt_o}, 32'd255);
    chk("sat_odd_perr_clear", {31'd0, pe_o}, 32'd0);

    // Every expected frame must have been observed.
    chk("q_even_empty", q_e.size(), 32'd0);
    chk("q_odd_empty", q_o.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
Receive-side counterpart of the serial parity generator: accepts a serial frame of DATA_BITS data bits followed by one parity bit, one bit per valid strobe. Reassembles the data word, checks it against the configured parity sense and reports a per-frame error flag. Keeps a saturating error counter for link-health monitoring.

Parameters:
DATA_BITS, 8, number of data bits per frame (2..32)
ODD_PARITY, 0, 0 = even parity expected (data XOR parity = 0); 1 = odd parity expected (data XOR parity = 1)

Ports:
clk  input  1  system clock; all logic is rising-edge triggered
reset  input  1  synchronous, active-low reset; reset=0 at a rising clk edge resets the block
w  input  1  serial bit; sampled only when w_valid=1
w_valid  input  1  qualifies w for this cycle
clear  input  1  synchronous abort; discards the frame in progress and returns to IDLE (err_count kept)
data_out  output  DATA_BITS  last completed data word; held until next frame_done
frame_done  output  1  one-cycle pulse when a frame completes
parity_err  output  1  parity result of last completed frame; held until next frame_done
busy  output  1  high while a frame is partially received (state DATA or PARITY)
err_count  output  8  count of frames with parity_err=1; saturates at 255

Behaviour:
- Reset (reset=0 at edge): state=IDLE, bit counter=0, shift reg=0, data_out=0, frame_done=0, parity_err=0, busy=0, err_count=0. Reset overrides clear and w_valid.
- Bit order: LSB first; data bit k is the (k+1)th accepted bit of the frame.
- Running parity register: XOR of all accepted bits in the frame, including the parity bit.
- w_valid=0: state, counter, shift reg and running parity hold; gaps of any length are legal.
- FSM:
  - IDLE: w_valid=1 -> store bit 0, counter=1, go DATA (if DATA_BITS=1 is not supported; min 2). busy=0.
  - DATA: w_valid=1 -> store bit at counter, counter+1; when the accepted bit is bit DATA_BITS-1 go PARITY.
  - PARITY: w_valid=1 -> sample parity bit, go IDLE; at the same edge register data_out=shift reg, parity_err=(running parity XOR w) != ODD_PARITY, frame_done=1.
- frame_done is registered: high exactly in the cycle after the parity bit is sampled, low otherwise.
- err_count increments at the same edge that sets parity_err=1; holds at 255.
- Back-to-back: w_valid=1 in the cycle where frame_done=1 is accepted as bit 0 of the next frame (state already IDLE); no dead cycle.
- busy: high in DATA and PARITY; low in IDLE, including the frame_done cycle.
- clear=1 (reset=1): state=IDLE, counter=0, shift reg=0, running parity=0. Any bit presented that cycle is discarded. data_out, parity_err, err_count unchanged. frame_done is not generated. clear has priority over w_valid.
- Reset mid-frame: partial frame discarded, all outputs return to reset values next cycle.
- No illegal-state lockup: unused state encodings go to IDLE.

Test Plan:
- Reset then even parity: bits of 0xA5 LSB first (1,0,1,0,0,1,0,1) + parity 0, w_valid held high -> frame_done pulses 1 cycle after the 9th bit, data_out=0xA5, parity_err=0, err_count=0.
- Parity error: 0xA5 + parity 1 -> parity_err=1, err_count=1; next frame 0x01 + parity 1 -> parity_err=0, err_count stays 1.
- Gapped stimulus: 0x3C + parity 0 with w_valid low for 3 cycles between every bit -> data_out=0x3C, parity_err=0; busy stays high from the first bit until the parity-bit edge.
- Back-to-back: 0xFF/p=0 then 0x80/p=1 with no idle cycle -> two frame_done pulses 9 cycles apart, data_out=0xFF then 0x80, both parity_err=0.
- Abort: 4 bits of a frame, clear=1 for one cycle, then full 0x5A/p=0 -> single frame_done, data_out=0x5A; reset=0 mid-frame -> all outputs 0, no frame_done.
- Saturation and odd mode: ODD_PARITY=1, 260 frames of 0x00/p=0 -> every parity_err=1, err_count stops at 255; frame 0x00/p=1 -> parity_err=0, err_count=255.
